// File: rtl/num_pkg.sv
// Shared definitions for the pulse-line debouncer: FSM state type and
// default parameter values.
package num_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int GLITCH_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } num_state_t;

  // The accepted level stays high while a falling edge is still being qualified.
  function automatic logic is_high_level(input num_state_t st);
    return (st == ST_HI) || (st == CHK_LO);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous raw line into the i_clk domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic s1_q;
  logic s2_q;

  // NOTE: non-blocking assignments make s2 take the old s1, giving two real flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= i_d;
      s2_q <= s1_q;
    end
  end

  assign o_q = s2_q;

endmodule

// File: rtl/num_debounce.sv
// Debounces a bouncing pulse line into a clean level with edge pulses and a
// saturating count of rejected transitions.
module num_debounce
  import num_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int GLITCH_W   = GLITCH_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_raw,
  output logic                o_num,
  output logic                o_rise,
  output logic                o_fall,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  localparam int                  CNT_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic                s2;
  num_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_bump;
  logic                num_q, num_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  sync_2ff u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_raw),
    .o_q   (s2)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_LO;
      cnt_q    <= '0;
      glitch_q <= '0;
      num_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      num_q    <= num_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    glitch_bump = 1'b0;
    unique case (state_q)
      ST_LO: if (s2) begin
        state_d = CHK_HI;
        cnt_d   = CNT_W'(1);
      end
      CHK_HI: if (!s2) begin
        state_d     = ST_LO;
        cnt_d       = '0;
        glitch_bump = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        state_d = ST_HI;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_HI: if (!s2) begin
        state_d = CHK_LO;
        cnt_d   = CNT_W'(1);
      end
      CHK_LO: if (s2) begin
        state_d     = ST_HI;
        cnt_d       = '0;
        glitch_bump = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        state_d = ST_LO;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase

    glitch_d = (glitch_bump && (glitch_q != GLITCH_MAX)) ? glitch_q + GLITCH_W'(1) : glitch_q;

    // The level is re-registered from the FSM state so the edge pulses line up with it.
    num_d  = is_high_level(state_q);
    rise_d = num_d & ~num_q;
    fall_d = ~num_d & num_q;
  end

  assign o_num        = num_q;
  assign o_rise       = rise_q;
  assign o_fall       = fall_q;
  assign o_glitch_cnt = glitch_q;

endmodule

// File: tb/tb_num_debounce.sv
// Self-checking bench for num_debounce: a run-length reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_num_debounce;

  localparam int DEB  = 4;
  localparam int GMAX = 255;

  logic       i_clk;
  logic       i_rst;
  logic       i_raw;
  logic       o_num;
  logic       o_rise;
  logic       o_fall;
  logic [7:0] o_glitch_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: raw history, accepted level, length of the current
  // run of samples disagreeing with it, and the glitch tally.
  int raw_hist[$];
  int m_level;
  int m_run;
  int m_glitch;
  int exp_num, exp_num_prev, exp_rise, exp_fall;

  // Observations of the DUT used by the directed scenarios.
  int rises, falls, alt_bad, last_pulse, down_cnt, prev_num_obs;
  int seq_tick, first_rise_tick, num_high_seen;

  num_debounce #(.DEB_CYCLES(DEB), .GLITCH_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_raw        (i_raw),
    .o_num        (o_num),
    .o_rise       (o_rise),
    .o_fall       (o_fall),
    .o_glitch_cnt (o_glitch_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    m_level      = 0;
    m_run        = 0;
    m_glitch     = 0;
    exp_num      = 0;
    exp_num_prev = 0;
    exp_rise     = 0;
    exp_fall     = 0;
    prev_num_obs = 0;
  endtask

  task automatic model_step(input int raw);
    int seen;
    raw_hist.push_back(raw);
    if (raw_hist.size() > 3) void'(raw_hist.pop_front());
    // The decision logic sees the raw value from two edges back.
    seen = (raw_hist.size() == 3) ? raw_hist[0] : 0;
    exp_num_prev = exp_num;
    exp_num      = m_level;
    exp_rise     = (exp_num == 1 && exp_num_prev == 0) ? 1 : 0;
    exp_fall     = (exp_num == 0 && exp_num_prev == 1) ? 1 : 0;
    if (seen != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = seen;
        m_run   = 0;
      end
    end else begin
      if (m_run > 0) m_glitch = (m_glitch >= GMAX) ? GMAX : m_glitch + 1;
      m_run = 0;
    end
  endtask

  task automatic compare();
    check("num", 32'(o_num), 32'(exp_num));
    check("rise", 32'(o_rise), 32'(exp_rise));
    check("fall", 32'(o_fall), 32'(exp_fall));
    check("glitch_cnt", 32'(o_glitch_cnt), 32'(m_glitch));
    check("rise_fall_exclusive", 32'(o_rise & o_fall), 32'd0);
  endtask

  task automatic observe();
    if (o_rise === 1'b1) begin
      rises++;
      if (last_pulse == 1) alt_bad++;
      last_pulse = 1;
      if (first_rise_tick < 0) first_rise_tick = seq_tick;
    end
    if (o_fall === 1'b1) begin
      falls++;
      if (last_pulse == 2) alt_bad++;
      last_pulse = 2;
    end
    if (o_num === 1'b1) num_high_seen = 1;
    if (o_num === 1'b1 && prev_num_obs == 0) down_cnt++;
    prev_num_obs = (o_num === 1'b1) ? 1 : 0;
    seq_tick++;
  endtask

  task automatic tick(input logic raw);
    i_raw = raw;
    @(posedge i_clk);
    #1;
    model_step(int'(raw));
    compare();
    observe();
  endtask

  task automatic seq_start();
    rises           = 0;
    falls           = 0;
    alt_bad         = 0;
    down_cnt        = 0;
    seq_tick        = 0;
    first_rise_tick = -1;
    num_high_seen   = 0;
  endtask

  // Asynchronous reset pulse of 10 ns launched 3 ns after the last edge.
  task automatic reset_pulse();
    #2;
    i_rst = 1'b1;
    #1;
    check("rst_async_num", 32'(o_num), 32'd0);
    check("rst_async_rise", 32'(o_rise), 32'd0);
    check("rst_async_fall", 32'(o_fall), 32'd0);
    check("rst_async_glitch", 32'(o_glitch_cnt), 32'd0);
    #9;
    i_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    last_pulse = 0;
    i_raw = 1'b0;
    i_rst = 1'b0;
    model_reset();
    seq_start();
    #1 i_rst = 1'b1;
    #1;
    check("reset_num", 32'(o_num), 32'd0);
    check("reset_rise", 32'(o_rise), 32'd0);
    check("reset_fall", 32'(o_fall), 32'd0);
    check("reset_glitch", 32'(o_glitch_cnt), 32'd0);
    #19 i_rst = 1'b0;

    // Clean rise: o_num follows 6 edges after the first sampling edge.
    seq_start();
    for (int i = 0; i < 20; i++) tick(1'b1);
    check("A_first_rise_edge", 32'(first_rise_tick), 32'd6);
    check("A_rises", 32'(rises), 32'd1);
    check("A_glitch", 32'(o_glitch_cnt), 32'd0);
    for (int i = 0; i < 20; i++) tick(1'b0);

    // Three-cycle pulse is rejected as one glitch.
    seq_start();
    for (int i = 0; i < 3; i++) tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    check("B_num_never_high", 32'(num_high_seen), 32'd0);
    check("B_glitch", 32'(o_glitch_cnt), 32'd1);

    // Exactly DEB cycles is accepted, and the return needs its own full window.
    seq_start();
    for (int i = 0; i < DEB; i++) tick(1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0);
    check("C_rises", 32'(rises), 32'd1);
    check("C_falls", 32'(falls), 32'd1);
    check("C_glitch", 32'(o_glitch_cnt), 32'd1);

    // Toggle every 10 cycles: 10 clean transitions.
    seq_start();
    for (int i = 0; i < 100; i++) tick(((i / 10) % 2) == 0);
    for (int i = 0; i < 20; i++) tick(1'b0);
    check("D_rises", 32'(rises), 32'd5);
    check("D_falls", 32'(falls), 32'd5);
    check("D_alternation", 32'(alt_bad), 32'd0);
    check("D_glitch", 32'(o_glitch_cnt), 32'd1);

    // Downstream counter fed by o_num counts exactly the rise pulses.
    seq_start();
    for (int i = 0; i < 200; i++) tick(((i / 20) % 2) == 0);
    for (int i = 0; i < 20; i++) tick(1'b0);
    check("E_down_vs_rise", 32'(down_cnt), 32'(rises));
    check("E_down_cnt", 32'(down_cnt), 32'd5);

    // Reset while qualifying a rise, then raw stays high after release.
    for (int i = 0; i < 4; i++) tick(1'b1);
    reset_pulse();
    seq_start();
    for (int i = 0; i < 20; i++) tick(1'b1);
    check("F_first_rise_edge", 32'(first_rise_tick), 32'd6);
    check("F_rises", 32'(rises), 32'd1);
    check("F_glitch", 32'(o_glitch_cnt), 32'd0);
    for (int i = 0; i < 20; i++) tick(1'b0);

    // Toggling every cycle: level never accepted, glitch count saturates.
    seq_start();
    for (int i = 0; i < 600; i++) tick((i % 2) == 0);
    for (int i = 0; i < 4; i++) tick(1'b0);
    check("G_num_never_high", 32'(num_high_seen), 32'd0);
    check("G_glitch_sat", 32'(o_glitch_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
